ctx_frame_ctrl: RTL
===================

Name: ctx_frame_ctrl

Overview:
- Frame-level sequencer for the context-modelling datapath (A/B/C/N context RAMs plus the Errval/stage4 pipeline).
- On each frame start it initialises every context entry through the RAM write port (port b): A=A_INIT, B=0, C=0, N=N_INIT.
- It then admits pixels into the datapath with a valid/ready handshake and counts them in.
- It drains the pipeline, counts coded outputs, and signals frame completion; it also owns the write-port mux between initialisation and datapath updates.

Parameters:
- NUM_CTX, 365, number of context entries initialised (addresses 0..NUM_CTX-1)
- A_INIT, 4, initial A value (max(2,(RANGE+32)/64) for 8-bit)
- N_INIT, 1, initial N value
- LEN_W, 20, width of frame pixel count

Ports:
- clk  in  1  clock
- reset  in  1  reset
- frame_start  in  1  one-cycle pulse; start new frame
- frame_len  in  LEN_W  pixels in frame; sampled on accepted frame_start
- in_valid  in  1  pixel source has Q/Ix/Px/sign valid
- in_ready  out  1  controller accepts pixel this cycle
- ctx_en  out  1  datapath enable (en of context pipeline) = in_valid & in_ready
- upd_we  in  1  datapath context write strobe
- upd_addr  in  9  datapath write address (Q_out)
- upd_A  in  13  datapath A update
- upd_B  in  7  datapath B update
- upd_C  in  8  datapath C update
- upd_N  in  7  datapath N update
- ram_addrb  out  9  context RAM write address
- ram_web  out  1  context RAM write enable
- ram_dinA  out  13  A write data
- ram_dinB  out  7  B write data
- ram_dinC  out  8  C write data
- ram_dinN  out  7  N write data
- coded_en  in  1  stage4 en_out; one per coded pixel
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse when last coded pixel counted
- err  out  1  sticky protocol error

Behaviour:
- Decided: reset is reset, asynchronous, active-low; clock is clk.
- Reset: state=IDLE; all counters 0; len_q=0; in_ready=0, frame_done=0, err=0, busy=0. Reset mid-frame aborts immediately, with no further RAM writes.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE: frame_start=1 -> latch len_q=frame_len, init_cnt=0, go INIT. frame_start while busy is ignored, with no effect on counters.
- INIT:
  - ram_web=1, ram_addrb=init_cnt, ram_dinA=A_INIT, ram_dinB=0, ram_dinC=0, ram_dinN=N_INIT.
  - init_cnt increments each cycle; when init_cnt==NUM_CTX-1 (last write this cycle), next state is RUN, or DONE if len_q==0.
  - Exactly NUM_CTX consecutive write cycles.
- RUN:
  - in_ready=1.
  - Accept when in_valid&in_ready; acc_cnt+1.
  - On the accept making acc_cnt==len_q, next state is DRAIN (in_ready=0 from next cycle).
- DRAIN: in_ready=0; wait for coded count.
- DONE: frame_done=1 for exactly one cycle; next state IDLE.
- Coded counting:
  - In RUN/DRAIN, coded_en increments cod_cnt.
  - When the increment makes cod_cnt==len_q, next state is DONE, even if still in RUN. This cannot legally happen before the last accept, but if it does, set err.
- Write-port mux (combinational on state): INIT drives the init values. Otherwise ram_web=upd_we and ram_addrb/din pass through upd_*.
- in_ready and ctx_en are combinational from state, so the datapath sees en in the same cycle as the accept.
- err (sticky until reset) is set on any of:
  - upd_we=1 during INIT; that write is dropped.
  - coded_en=1 in IDLE, INIT or DONE.
  - cod_cnt would exceed acc_cnt.
- Counters are LEN_W wide with no wrap. frame_len=2^LEN_W-1 is legal.
- Simultaneous accept and coded_en in the same cycle: both counters update.
- frame_start in DONE is ignored. A new frame needs a pulse in IDLE, i.e. at least 1 cycle after frame_done.

Test Plan:
- Reset, frame_start with frame_len=4 -> exactly 365 cycles with ram_web=1, addrb 0..364, dinA=4, B=0, C=0, N=1; in_ready first high on cycle 366 after the pulse.
- frame_len=4, in_valid held high, coded_en returned 3 cycles after each ctx_en -> 4 ctx_en pulses, in_ready low after the 4th, a single frame_done 1 cycle after the 4th coded_en, busy low next cycle.
- frame_len=0 -> 365 init writes, then frame_done pulse, no ctx_en ever high.
- In RUN, upd_we=1 with addr=0x10, A=0x123 -> ram_web=1, addrb=0x10, dinA=0x123 same cycle; repeat during INIT -> write dropped, err=1.
- frame_start pulsed mid-INIT (cycle 100) and mid-RUN -> ignored: init still ends at 365 writes, counters unchanged.
- Reset asserted during DRAIN -> outputs 0 immediately; new frame_start afterward performs a full re-init and a normal frame with frame_len=2.

Source files
------------

// File: rtl/ctx_frame_ctrl.sv
// Frame-level sequencer for the context-modelling datapath: clears the A/B/C/N
// context RAMs, admits pixels with valid/ready, drains the pipeline and flags completion.
module ctx_frame_ctrl #(
    parameter int NUM_CTX = 365,
    parameter int A_INIT  = 4,
    parameter int N_INIT  = 1,
    parameter int LEN_W   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_start,
    input  logic [LEN_W-1:0] frame_len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ctx_en,
    input  logic             upd_we,
    input  logic [8:0]       upd_addr,
    input  logic [12:0]      upd_A,
    input  logic [6:0]       upd_B,
    input  logic [7:0]       upd_C,
    input  logic [6:0]       upd_N,
    output logic [8:0]       ram_addrb,
    output logic             ram_web,
    output logic [12:0]      ram_dinA,
    output logic [6:0]       ram_dinB,
    output logic [7:0]       ram_dinC,
    output logic [6:0]       ram_dinN,
    input  logic             coded_en,
    output logic             busy,
    output logic             frame_done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [8:0]       init_cnt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] acc_cnt;
    logic [LEN_W-1:0] cod_cnt;
    logic [LEN_W-1:0] acc_nxt;
    logic [LEN_W-1:0] cod_nxt;
    logic             accept;
    logic             cod_inc;
    logic             acc_last;
    logic             cod_last;
    logic             init_last;
    logic             err_set;

    // Handshake and counter arithmetic shared by the state logic and the registers.
    always_comb begin
        accept    = (state == S_RUN) && in_valid;
        cod_inc   = coded_en && ((state == S_RUN) || (state == S_DRAIN));
        acc_nxt   = acc_cnt + LEN_W'(accept);
        cod_nxt   = cod_cnt + LEN_W'(cod_inc);
        acc_last  = accept && (acc_nxt == len_q);
        cod_last  = cod_inc && (cod_nxt == len_q);
        init_last = (init_cnt == 9'(NUM_CTX - 1));
        err_set   = ((state == S_INIT) && upd_we)
                  || (coded_en && ((state == S_IDLE) || (state == S_INIT) || (state == S_DONE)))
                  || (cod_inc && (cod_nxt > acc_nxt));
    end

    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        ctx_en     = accept;
        busy       = (state != S_IDLE);
        frame_done = 1'b0;
        ram_web    = upd_we;
        ram_addrb  = upd_addr;
        ram_dinA   = upd_A;
        ram_dinB   = upd_B;
        ram_dinC   = upd_C;
        ram_dinN   = upd_N;

        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_INIT;
            end
            S_INIT: begin
                // Init owns the write port; a datapath write here is dropped.
                ram_web   = 1'b1;
                ram_addrb = init_cnt;
                ram_dinA  = 13'(A_INIT);
                ram_dinB  = '0;
                ram_dinC  = '0;
                ram_dinN  = 7'(N_INIT);
                if (init_last) state_nxt = (len_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                in_ready = 1'b1;
                if (cod_last)      state_nxt = S_DONE;
                else if (acc_last) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (cod_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            init_cnt <= '0;
            len_q    <= '0;
            acc_cnt  <= '0;
            cod_cnt  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (err_set) err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        len_q    <= frame_len;
                        init_cnt <= '0;
                        acc_cnt  <= '0;
                        cod_cnt  <= '0;
                    end
                end
                S_INIT: init_cnt <= init_cnt + 9'd1;
                S_RUN, S_DRAIN: begin
                    acc_cnt <= acc_nxt;
                    cod_cnt <= cod_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule
